image_upscale_writer: RTL

IMAGE_UPSCALE_WRITER -- requirements
Module: image_upscale_writer

---
 rtl/image_upscale_writer_if.sv | 25 ++
 rtl/image_upscale_writer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/image_upscale_writer_if.sv
// Pixel-stream / memory-write bundle for image_upscale_writer.
//   in_valid, in_data : downscaled pixel stream into the writer
//   in_ready          : writer accepts in_data this cycle
//   wr_full           : memory write path cannot take a write this cycle
//   wr_en, wr_addr, wr_data : write strobe, 23-bit word address, pixel
// master = writer side, slave = source / memory side.
interface image_upscale_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_full;
  logic        wr_en;
  logic [22:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    input  in_valid, in_data, wr_full,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data, wr_full,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/image_upscale_writer.sv
// Nearest-neighbour upscaler: buffers one downscaled line of IMG_W/BLK
// pixels, then writes it out as BLK full-resolution rows, each input pixel
// replicated BLK times horizontally.  Repeats for IMG_H/BLK input lines.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle frame start (honoured only when idle)
//   bus      : pixel input stream and memory write port (master side)
//   busy     : high whenever not idle
//   done     : one-cycle pulse when the frame's last write has been made
module image_upscale_writer #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          BLK       = 8,
  parameter logic [22:0] BASE_ADDR = 23'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  image_upscale_writer_if.master     bus,
  output logic                       busy,
  output logic                       done
);
  localparam int COLS  = IMG_W / BLK;
  localparam int ROWS  = IMG_H / BLK;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SUB_W = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BLK - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       linebuf [COLS];
  logic [COL_W-1:0] col;       // fill position in the line buffer
  logic [COL_W-1:0] bx;        // output column / BLK
  logic [SUB_W-1:0] bs;        // output column % BLK
  logic [SUB_W-1:0] r;         // sub-row within the current block row
  logic [ROW_W-1:0] q;         // input row
  logic [22:0]      wr_addr;
  logic             in_ready, wr_en;
  logic [7:0]       wr_data;
  logic             accept, wr_fire, line_end;

  // Output column tracked as (bx, bs) so the buffer read needs no divider.
  assign line_end = (bx == COL_LAST) && (bs == SUB_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'd0;
    done      = 1'b0;
    accept    = 1'b0;
    wr_fire   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (accept && col == COL_LAST) state_nxt = EMIT;
      end
      EMIT: begin
        wr_en   = !bus.wr_full;
        wr_fire = wr_en;
        wr_data = linebuf[bx];
        if (wr_fire && line_end && r == SUB_LAST)
          state_nxt = (q == ROW_LAST) ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= BASE_ADDR;
      col     <= '0;
      bx      <= '0;
      bs      <= '0;
      r       <= '0;
      q       <= '0;
    end else begin
      if (state == IDLE && start) begin
        wr_addr <= BASE_ADDR;
        col     <= '0;
        bx      <= '0;
        bs      <= '0;
        r       <= '0;
        q       <= '0;
      end
      // col wraps to 0 on the last accept so the next FILL starts clean.
      if (accept) col <= (col == COL_LAST) ? '0 : col + 1'b1;
      if (wr_fire) begin
        wr_addr <= wr_addr + 23'd1;
        if (bs == SUB_LAST) begin
          bs <= '0;
          bx <= (bx == COL_LAST) ? '0 : bx + 1'b1;
        end else begin
          bs <= bs + 1'b1;
        end
        if (line_end) begin
          r <= (r == SUB_LAST) ? '0 : r + 1'b1;
          if (r == SUB_LAST) q <= q + 1'b1;
        end
      end
    end
  end

  // Line buffer holds data only; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) linebuf[col] <= bus.in_data;
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
endmodule
